// File: rtl/mmc_defs.sv
// mmc_defs: shared constants and state encoding for the matrix-multiply
// CU scheduler and its round-robin arbiter.
//   N       matrix dimension (N*N output elements)
//   NUM_CU  number of computation units
//   DATA_W  result width
//   ADDR_W  element index / MEM_C address width
package mmc_defs;

  localparam int N      = 32;
  localparam int NUM_CU = 4;
  localparam int DATA_W = 21;
  localparam int ADDR_W = 10;
  localparam int ELEMS  = N * N;
  localparam int PTR_W  = (NUM_CU > 1) ? $clog2(NUM_CU) : 1;

  // Counters are one bit wider than an index so they can hold ELEMS itself.
  localparam logic [ADDR_W:0] ELEMS_C = ADDR_W'(0) + (ADDR_W + 1)'(ELEMS);
  localparam logic [ADDR_W:0] LAST_C  = ELEMS_C - 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Round-robin pointer advance: wraps at NUM_CU even when it is not a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (int'(p) == NUM_CU - 1) ? '0 : p + 1'b1;
  endfunction

endpackage

// File: rtl/mmc_rr_arbiter.sv
// mmc_rr_arbiter: combinational round-robin arbiter.
// Ports:
//   req          request vector, one bit per requester
//   ptr          requester index where the search starts
//   grant        one-hot grant (all zero when nothing requests)
//   grant_idx    encoded index of the granted requester
//   grant_valid  a grant was issued this cycle
// The rotating pointer register lives in the caller.
module mmc_rr_arbiter
  import mmc_defs::*;
#(
  parameter int WIDTH = NUM_CU,
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [WIDTH-1:0] grant,
  output logic [IW-1:0]    grant_idx,
  output logic             grant_valid
);

  int cand;

  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    cand        = 0;
    for (int k = 0; k < WIDTH; k++) begin
      cand = (int'(ptr) + k) % WIDTH;
      if (!grant_valid && req[IW'(cand)]) begin
        grant_valid         = 1'b1;
        grant[IW'(cand)]    = 1'b1;
        grant_idx           = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/mmc_cu_scheduler.sv
// mmc_cu_scheduler: hands output-element indices 0..N*N-1 to idle CUs and
// funnels their results, one per cycle, into the MEM_C write port.
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   start       begin a full matrix (honoured in IDLE or DONE only)
//   done        high from completion until next accepted start / reset
//   cu_start    registered one-cycle dispatch pulse per CU
//   cu_idx      per-CU element index, packed NUM_CU x ADDR_W
//   cu_valid    per-CU result ready, held until acked
//   cu_result   per-CU result, packed NUM_CU x DATA_W
//   cu_ack      one-hot combinational grant
//   c_we        MEM_C write enable (= |cu_ack)
//   c_addr      MEM_C write address (index of the granted CU)
//   c_din       MEM_C write data (result of the granted CU)
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | after reset; waiting for start
// RUN   | dispatching indices and collecting results
// DONE  | all N*N results written; done held; start launches a rerun
module mmc_cu_scheduler
  import mmc_defs::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic                     done,
  output logic [NUM_CU-1:0]        cu_start,
  output logic [NUM_CU*ADDR_W-1:0] cu_idx,
  input  logic [NUM_CU-1:0]        cu_valid,
  input  logic [NUM_CU*DATA_W-1:0] cu_result,
  output logic [NUM_CU-1:0]        cu_ack,
  output logic                     c_we,
  output logic [ADDR_W-1:0]        c_addr,
  output logic [DATA_W-1:0]        c_din
);

  state_t                          state;
  logic [NUM_CU-1:0][ADDR_W-1:0]   idx_q;
  logic [NUM_CU-1:0][DATA_W-1:0]   res_v;
  logic [NUM_CU-1:0]               busy;
  logic [NUM_CU-1:0]               busy_nxt;
  logic [ADDR_W:0]                 next_idx;
  logic [ADDR_W:0]                 wr_cnt;
  logic [PTR_W-1:0]                rr_ptr;

  logic [NUM_CU-1:0]               req;
  logic [NUM_CU-1:0]               grant;
  logic [PTR_W-1:0]                gnt_idx;
  logic                            gnt_valid;
  logic                            disp_en;
  logic [PTR_W-1:0]                disp_sel;

  assign res_v  = cu_result;
  assign cu_idx = idx_q;

  // Outside RUN no request reaches the arbiter, so ack/we stay low and a
  // valid from a CU that was never dispatched is ignored.
  assign req = (state == RUN) ? (cu_valid & busy) : '0;

  mmc_rr_arbiter #(.WIDTH(NUM_CU)) u_arb (
    .req         (req),
    .ptr         (rr_ptr),
    .grant       (grant),
    .grant_idx   (gnt_idx),
    .grant_valid (gnt_valid)
  );

  assign cu_ack = grant;
  assign c_we   = gnt_valid;
  assign c_addr = gnt_valid ? idx_q[gnt_idx] : '0;
  assign c_din  = gnt_valid ? res_v[gnt_idx] : '0;

  // Lowest idle CU. busy is the registered value, so a CU acked this
  // cycle is only dispatchable from the next one.
  always_comb begin
    disp_sel = '0;
    disp_en  = 1'b0;
    for (int i = NUM_CU - 1; i >= 0; i--) begin
      if (!busy[PTR_W'(i)]) begin
        disp_sel = PTR_W'(i);
        disp_en  = 1'b1;
      end
    end
    if (state != RUN || next_idx >= ELEMS_C) disp_en = 1'b0;
  end

  always_comb begin
    busy_nxt = busy & ~grant;
    if (disp_en) busy_nxt[disp_sel] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      done     <= 1'b0;
      cu_start <= '0;
      idx_q    <= '0;
      busy     <= '0;
      next_idx <= '0;
      wr_cnt   <= '0;
      rr_ptr   <= '0;
    end else begin
      cu_start <= '0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state    <= RUN;
            done     <= 1'b0;
            busy     <= '0;
            next_idx <= '0;
            wr_cnt   <= '0;
          end
        end
        RUN: begin
          busy <= busy_nxt;
          if (disp_en) begin
            cu_start[disp_sel] <= 1'b1;
            idx_q[disp_sel]    <= next_idx[ADDR_W-1:0];
            next_idx           <= next_idx + 1'b1;
          end
          if (gnt_valid) begin
            wr_cnt <= wr_cnt + 1'b1;
            rr_ptr <= ptr_inc(gnt_idx);
            if (wr_cnt == LAST_C) begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
